rf_access_ctrl: RTL

Sequencer and arbiter for the 16x32 register file (RF). The RF performs either a read cycle (we=0: captures ports 1/2 and the write_reg word into registered outputs) or a half-word write cycle (we=1, RF_HL selects the half, the other half merged from the captured write_reg word), never both.
This block accepts writeback requests (LO half, HI half, FULL word) and operand read requests from decode. It generates the RF fetch/write sequences and lets reads piggyback on every non-write cycle.

---
 rtl/rf_access_ctrl_pkg.sv | 20 ++
 rtl/rf_access_ctrl_if.sv | 39 +++
 rtl/rf_access_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/rf_access_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
// State encoding is fixed so that a waveform shows the same codes as the RF documentation.
package rf_ctrl_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = DATA_W / 2;

    localparam logic [1:0] WB_MODE_LO   = 2'b00;
    localparam logic [1:0] WB_MODE_HI   = 2'b01;
    localparam logic [1:0] WB_MODE_FULL = 2'b10;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWHi      = 2'd1,
        StWRefetch = 2'd2,
        StWLo      = 2'd3
    } state_e;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Writeback, operand-read and RF-side signals of the access controller.
// The master side issues requests; the slave side is the controller itself.
interface rf_access_ctrl_if;
    import rf_ctrl_pkg::*;

    logic              wb_valid;
    logic              wb_ready;
    logic [1:0]        wb_mode;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_done;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_done;

    logic              busy;
    logic              rf_we;
    logic              rf_hl;
    logic [ADDR_W-1:0] rf_port1;
    logic [ADDR_W-1:0] rf_port2;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_data_in;

    modport master (
        output wb_valid, wb_mode, wb_addr, wb_data, rd_valid, rd_addr1, rd_addr2,
        input  wb_ready, wb_done, rd_ready, rd_done, busy,
        input  rf_we, rf_hl, rf_port1, rf_port2, rf_write_reg, rf_data_in
    );

    modport slave (
        input  wb_valid, wb_mode, wb_addr, wb_data, rd_valid, rd_addr1, rd_addr2,
        output wb_ready, wb_done, rd_ready, rd_done, busy,
        output rf_we, rf_hl, rf_port1, rf_port2, rf_write_reg, rf_data_in
    );

endinterface

// File: rtl/rf_access_ctrl.sv
// Sequences half/full-word writebacks into the 16x32 RF and lets operand reads
// ride on every cycle in which the RF is not writing.
module rf_access_ctrl
    import rf_ctrl_pkg::*;
(
    input logic             clk,
    input logic             reset,
    rf_access_ctrl_if.slave bus
);

    state_e            state_q;
    logic [ADDR_W-1:0] tgt_addr_q;
    logic [DATA_W-1:0] tgt_data_q;
    logic [1:0]        tgt_mode_q;
    logic              wb_done_q;
    logic              rd_done_q;

    logic              in_write;
    logic              hazard;
    logic              wb_ready;
    logic              rd_ready;
    logic              rf_we;
    logic              busy;
    logic              rf_hl;
    logic [DATA_W-1:0] rf_data_in;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [ADDR_W-1:0] rf_port1;
    logic [ADDR_W-1:0] rf_port2;

    always_comb begin
        in_write = (state_q == StWHi) || (state_q == StWLo);
        // Reading the target mid-sequence could return {new_hi, old_lo}
        hazard   = (state_q != StIdle) &&
                   ((bus.rd_addr1 == tgt_addr_q) || (bus.rd_addr2 == tgt_addr_q));
        rf_we    = reset && in_write;
        busy     = reset && (state_q != StIdle);
        wb_ready = reset && (state_q == StIdle) && bus.wb_valid;
        rd_ready = reset && bus.rd_valid && !rf_we && !hazard;
        rf_hl    = rf_we && (state_q == StWHi);
        rf_data_in = rf_we ? tgt_data_q : '0;
        // In IDLE the write_reg port prefetches the incoming target's old word
        rf_write_reg = (state_q == StIdle) ? bus.wb_addr : tgt_addr_q;
        rf_port1 = rf_we ? '0 : bus.rd_addr1;
        rf_port2 = rf_we ? '0 : bus.rd_addr2;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            tgt_addr_q <= '0;
            tgt_data_q <= '0;
            tgt_mode_q <= '0;
            wb_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            rd_done_q <= rd_ready;
            wb_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wb_ready) begin
                        tgt_addr_q <= bus.wb_addr;
                        tgt_data_q <= bus.wb_data;
                        tgt_mode_q <= bus.wb_mode;
                        state_q    <= (bus.wb_mode == WB_MODE_LO) ? StWLo : StWHi;
                    end
                end
                StWHi: begin
                    // Mode 11 behaves as FULL: anything but HI continues to the low half
                    state_q   <= (tgt_mode_q == WB_MODE_HI) ? StIdle : StWRefetch;
                    wb_done_q <= (tgt_mode_q == WB_MODE_HI);
                end
                StWRefetch: begin
                    state_q <= StWLo;
                end
                StWLo: begin
                    state_q   <= StIdle;
                    wb_done_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.wb_ready     = wb_ready;
    assign bus.wb_done      = wb_done_q;
    assign bus.rd_ready     = rd_ready;
    assign bus.rd_done      = rd_done_q;
    assign bus.busy         = busy;
    assign bus.rf_we        = rf_we;
    assign bus.rf_hl        = rf_hl;
    assign bus.rf_port1     = rf_port1;
    assign bus.rf_port2     = rf_port2;
    assign bus.rf_write_reg = rf_write_reg;
    assign bus.rf_data_in   = rf_data_in;

endmodule
